// File: rtl/bht_table_if.sv
// Fetch-side read port and execute-side update port of the branch history table.
interface bht_table_if;
   logic [31:0] rd_pc;
   logic [31:0] rd_inst;
   logic        pred_taken;
   logic        pred_is_cti;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        ready;

   modport master (
      output rd_pc, rd_inst, upd_valid, upd_pc, upd_taken,
      input  pred_taken, pred_is_cti, ready
   );

   modport slave (
      input  rd_pc, rd_inst, upd_valid, upd_pc, upd_taken,
      output pred_taken, pred_is_cti, ready
   );
endinterface

// File: rtl/bht_table.sv
// Branch history table of saturating counters; combinational prediction, trained on resolved branches.
// Optional gshare indexing (global history XOR PC) is enabled with macro BHT_GSHARE_EN.
module bht_table #(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = 6,
   parameter int CTR_W   = 2
) (
   input  logic      clk,
   input  logic      rst,
   bht_table_if.slave bus
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ENTRIES - 1);

   function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
      return (&c) ? c : c + CTR_W'(1);
   endfunction

   function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
      return (c == '0) ? c : c - CTR_W'(1);
   endfunction

   state_t           state_q, state_d;
   logic [IDX_W-1:0] walk_q, walk_d;
   logic [CTR_W-1:0] ctr_q [ENTRIES];

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [CTR_W-1:0] ctr_d;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [4:0]       opc;
   logic             run_upd;

   assign run_upd = (state_q == S_RUN) && bus.upd_valid;

`ifdef BHT_GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;

   assign rd_idx  = bus.rd_pc[IDX_W+1:2] ^ ghr_q;
   assign upd_idx = bus.upd_pc[IDX_W+1:2] ^ ghr_q;

   always_comb begin
      ghr_d = ghr_q;
      if (run_upd)
         ghr_d = {ghr_q[IDX_W-2:0], bus.upd_taken};
   end

   always_ff @(posedge clk) begin
      if (rst) ghr_q <= '0;
      else     ghr_q <= ghr_d;
   end
`else
   assign rd_idx  = bus.rd_pc[IDX_W+1:2];
   assign upd_idx = bus.upd_pc[IDX_W+1:2];
`endif

   // Control: init walk, then run; a single write port serves both
   always_comb begin
      state_d = state_q;
      walk_d  = walk_q;
      wr_en   = 1'b0;
      wr_idx  = upd_idx;
      ctr_d   = ctr_q[upd_idx];
      case (state_q)
         S_INIT: begin
            wr_en  = 1'b1;
            wr_idx = walk_q;
            ctr_d  = CTR_WEAK_NT;
            walk_d = walk_q + IDX_W'(1);
            if (walk_q == LAST_IDX)
               state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.upd_valid) begin
               wr_en = 1'b1;
               ctr_d = bus.upd_taken ? sat_inc(ctr_q[upd_idx]) : sat_dec(ctr_q[upd_idx]);
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         walk_q  <= '0;
      end else begin
         state_q <= state_d;
         walk_q  <= walk_d;
      end
   end

   // Counter storage has no reset; the walk after reset initialises it
   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         ctr_q[wr_idx] <= ctr_d;
   end

   assign opc = bus.rd_inst[6:2];

   always_comb begin
      bus.pred_taken  = 1'b0;
      bus.pred_is_cti = 1'b0;
      if (opc == OPC_JAL || opc == OPC_JALR) begin
         bus.pred_taken  = 1'b1;
         bus.pred_is_cti = 1'b1;
      end else if (opc == OPC_BRANCH) begin
         bus.pred_is_cti = 1'b1;
         bus.pred_taken  = (state_q == S_RUN) && ctr_q[rd_idx][CTR_W-1];
      end
   end

   assign bus.ready = (state_q == S_RUN);

   logic unused;
   assign unused = ^{bus.rd_pc[31:IDX_W+2], bus.rd_pc[1:0], bus.upd_pc[31:IDX_W+2],
                     bus.upd_pc[1:0], bus.rd_inst[31:7], bus.rd_inst[1:0]};

endmodule

// File: tb/tb_bht_table.sv
// Directed bench for bht_table (16 entries, 2-bit counters): init walk, training, saturation, opcodes, resets.
module tb_bht_table;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bht_table_if bus ();

   bht_table #(.ENTRIES(16), .IDX_W(4), .CTR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   localparam logic [31:0] BR   = 32'h0000_0063;
   localparam logic [31:0] JAL  = 32'h0000_006F;
   localparam logic [31:0] JALR = 32'h0000_0067;
   localparam logic [31:0] ADD  = 32'h0000_0033;

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] rpc;
      logic [31:0] rinst;
      logic        e_pred;
      logic        e_cti;
      logic        e_rdy;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   vec_t vecs[$];

   function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] rpc,
                               logic [31:0] rinst, logic e_pred, logic e_cti);
      vec_t v;
      v.uv = uv; v.upc = upc; v.ut = ut; v.rpc = rpc; v.rinst = rinst;
      v.e_pred = e_pred; v.e_cti = e_cti; v.e_rdy = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] rpc, input logic [31:0] rinst);
      rst           = r;
      bus.upd_valid = uv;
      bus.upd_pc    = upc;
      bus.upd_taken = ut;
      bus.rd_pc     = rpc;
      bus.rd_inst   = rinst;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Walk of n cycles with taken updates pending; none may land, ready stays low
   task automatic walk(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         case (k % 3)
            0: drive(1'b0, 1'b1, 32'h40, 1'b1, 32'(k * 4), BR);
            1: drive(1'b0, 1'b1, 32'h0C, 1'b1, 32'(k * 4), JAL);
            default: drive(1'b0, 1'b1, 32'h08, 1'b1, 32'(k * 4), ADD);
         endcase
         @(negedge clk);
         chk({tag, "_ready"}, k, bus.ready, 1'b0);
         chk({tag, "_pred"}, k, bus.pred_taken, (k % 3) == 1);
         chk({tag, "_cti"}, k, bus.pred_is_cti, (k % 3) != 2);
         next_cycle();
      end
   endtask

   task automatic pulse_rst();
      drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, BR);
      next_cycle();
   endtask

   initial begin
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, BR,  0, 1)); // 01, same-cycle read sees old value
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, BR,  1, 1)); // 10
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, BR,  1, 1)); // 11
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, BR,  1, 1)); // 11 saturated
      vecs.push_back(mk(0, 32'h40, 0, 32'h80, BR,  1, 1)); // alias of index 0
      vecs.push_back(mk(0, 32'h40, 0, 32'h44, BR,  0, 1)); // index 1 untouched
      vecs.push_back(mk(1, 32'h40, 0, 32'h40, BR,  1, 1)); // 11
      vecs.push_back(mk(1, 32'h40, 0, 32'h40, BR,  1, 1)); // 10
      vecs.push_back(mk(1, 32'h40, 0, 32'h40, BR,  0, 1)); // 01
      vecs.push_back(mk(1, 32'h40, 0, 32'h40, BR,  0, 1)); // 00
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, BR,  0, 1)); // 00 saturated low
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, BR,  0, 1)); // 01
      vecs.push_back(mk(0, 32'h40, 0, 32'h40, BR,  1, 1)); // 10
      vecs.push_back(mk(1, 32'h0C, 1, 32'h0C, BR,  0, 1)); // index 3 at 01 after init
      vecs.push_back(mk(0, 32'h0C, 0, 32'h0C, BR,  1, 1)); // 10
      vecs.push_back(mk(1, 32'h08, 0, 32'h08, BR,  0, 1)); // index 2: 01 -> 00
      vecs.push_back(mk(1, 32'h08, 1, 32'h08, BR,  0, 1)); // 00 -> 01
      vecs.push_back(mk(1, 32'h08, 1, 32'h08, BR,  0, 1)); // 01 -> 10
      vecs.push_back(mk(0, 32'h08, 0, 32'h08, BR,  1, 1));
      vecs.push_back(mk(0, 32'h00, 0, 32'h44, JAL, 1, 1));
      vecs.push_back(mk(0, 32'h00, 0, 32'h44, ADD, 0, 0));
      vecs.push_back(mk(0, 32'h00, 0, 32'h40, JALR,1, 1));
      vecs.push_back(mk(0, 32'h44, 1, 32'h40, ADD, 0, 0)); // upd_valid low: no training
      vecs.push_back(mk(1, 32'h44, 1, 32'h44, BR,  0, 1)); // index 1 still 01
      vecs.push_back(mk(0, 32'h44, 0, 32'h44, BR,  1, 1)); // 10

      pulse_rst();
      walk(16, "init");

      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].rpc, vecs[i].rinst);
         @(negedge clk);
         chk("vec_ready", i, bus.ready, vecs[i].e_rdy);
         chk("vec_pred", i, bus.pred_taken, vecs[i].e_pred);
         chk("vec_cti", i, bus.pred_is_cti, vecs[i].e_cti);
         next_cycle();
      end

      // Reset during RUN, then again partway through the walk
      pulse_rst();
      walk(5, "rwalk_a");
      pulse_rst();
      walk(16, "rwalk_b");

      // Index 0 was at 10 before reset; the fresh walk must bring it back to 01
      drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, BR);
      @(negedge clk);
      chk("post_rst_ready", 0, bus.ready, 1'b1);
      chk("post_rst_pred", 0, bus.pred_taken, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 32'h40, 1'b0, 32'h40, BR);
      @(negedge clk);
      chk("post_rst_pred", 1, bus.pred_taken, 1'b1);
      chk("post_rst_ready", 1, bus.ready, 1'b1);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bht_table.md
Name: bht_table

Overview:
- Parametrised branch history table; successor to the single-counter 2-bit predictor.
- Holds ENTRIES saturating counters of CTR_W bits, indexed by fetch PC.
- Gives a taken/not-taken prediction for the instruction in fetch and trains on resolved branches from execute.
- Sits between the fetch stage (read port) and the branch resolution logic (update port).

Parameters:
- ENTRIES, 64, number of counters; power of two, minimum 4.
- IDX_W, 6, log2(ENTRIES); index taken from PC[IDX_W+1:2].
- CTR_W, 2, counter width in bits, minimum 1; counter MSB = predict taken.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_pc  in  32  PC of instruction in fetch.
- rd_inst  in  32  instruction word in fetch.
- pred_taken  out  1  combinational prediction for rd_pc/rd_inst.
- pred_is_cti  out  1  combinational; 1 when rd_inst is branch, JAL or JALR.
- upd_valid  in  1  resolved conditional branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome of the resolved branch.
- ready  out  1  table initialised; 0 during init walk.

Behaviour:
- Opcode decode on rd_inst[6:2]:
  - 11011 (JAL) or 11001 (JALR): pred_taken=1 and pred_is_cti=1 regardless of the table.
  - 11000 (BRANCH): pred_is_cti=1; pred_taken = MSB of counter[rd_idx].
  - Any other opcode: pred_taken=0, pred_is_cti=0.
- Read path is combinational from table registers; no read latency.
- States:
  - INIT: walk counter i; each cycle writes counter[i] = weakly-not-taken (2^(CTR_W-1)-1; 0 when CTR_W=1). i increments; after writing i=ENTRIES-1, go to RUN. Takes exactly ENTRIES cycles after rst deasserts.
  - RUN: normal operation.
- Reset:
  - rst=1 forces state INIT, i=0, ready=0; GHR=0 if present.
  - Counters are not cleared directly by rst; the INIT walk clears them.
  - Reset asserted mid-walk or mid-RUN restarts the walk from 0.
- During INIT:
  - ready=0.
  - pred_taken=0 for branches; JAL/JALR still predict 1.
  - upd_valid is ignored.
- Update in RUN, when upd_valid=1, on the next rising edge:
  - upd_taken=1: counter[upd_idx] increments, saturating at 2^CTR_W-1.
  - upd_taken=0: counter[upd_idx] decrements, saturating at 0.
  - No wrap-around in either direction.
- Read and update to the same index in the same cycle: pred_taken reflects the pre-update value (no bypass). The new value is visible the following cycle.
- ready goes to 1 on the cycle after the last init write and stays 1 until rst.

Optional Feature:
- Macro BHT_GSHARE_EN.
- Defined:
  - An IDX_W-bit global history register GHR is added.
  - rd_idx = PC[IDX_W+1:2] XOR GHR; upd_idx = upd_pc[IDX_W+1:2] XOR GHR (same GHR value for both in a cycle).
  - On each RUN update, GHR <= {GHR[IDX_W-2:0], upd_taken} at the same edge as the counter write.
  - rst clears GHR to 0; GHR does not shift during INIT.
- Not defined:
  - No GHR exists.
  - rd_idx = rd_pc[IDX_W+1:2]; upd_idx = upd_pc[IDX_W+1:2].

Test Plan (ENTRIES=16, IDX_W=4, CTR_W=2, macro undefined unless noted):
- Init timing: pulse rst 1 cycle, hold upd_valid=1 throughout -> ready=0 for 16 cycles, 1 on cycle 17; a BRANCH at any PC predicts 0; updates during init leave all counters at 01.
- Saturation up: 4 updates taken at upd_pc=0x40 -> counter 01->10->11->11->11; BRANCH at rd_pc=0x40 predicts 1 after the first update. Then 4 not-taken updates -> 11->10->01->00->00; predict 0 after 2 updates.
- Aliasing: train taken at 0x40 -> rd_pc 0x80 (same index 0) predicts 1; rd_pc 0x44 predicts 0.
- Same-cycle read/update: counter at 01, read 0x40 while updating 0x40 taken -> pred_taken=0 that cycle, 1 next cycle.
- Opcodes: rd_inst opcode 1101111 -> pred_taken=1, pred_is_cti=1; opcode 0110011 -> both 0. Both hold even during INIT.
- BHT_GSHARE_EN: after updates taken,not-taken,taken (GHR=0101) on a PC with index 0, a read at rd_pc=0x0 uses index 5; reset mid-RUN -> GHR=0, ready=0, walk restarts.
